id_ex_operand_u: RTL and testbench
==================================

ID_EX_OPERAND_U -- requirements
Module: id_ex_operand_u

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-002 clk  in  1  pipeline clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 id_valid  in  1  ID holds a real instruction.
REQ-005 id_pc  in  32  PC of the ID instruction.
REQ-006 id_rs1, id_rs2, id_rd  in  5 each  ID register indices.
REQ-007 id_wr_reg_n  in  1  ID instruction does not write rd (active-low write enable).
REQ-008 id_is_load  in  1  ID instruction is a load.
REQ-009 rs1_data, rs2_data  in  32 each  register-file read values.
REQ-010 forward_a, forward_b  in  2 each  forward codes from the forwarding unit: 00 regfile, 01 EX result, 10 MEM result.
REQ-011 ex_fwd_data, mem_fwd_data  in  32 each  values to forward from EX and MEM.
REQ-012 flush  in  1  squash the ID instruction (taken branch or jump).
REQ-013 hold  in  1  downstream busy; freeze the ID/EX register.
REQ-014 stall  out  1  freeze IF/ID this cycle.
REQ-015 ex_valid, ex_wr_reg_n, ex_is_load  out  1 each  registered ID/EX control.
REQ-016 ex_pc, ex_a, ex_b  out  32 each  registered PC and operands.
REQ-017 ex_rd  out  5  registered destination index.
REQ-018 stall_cnt  out  16  count of load-use bubbles, saturating.

Function
REQ-019 Operand mux (combinational): a_sel = rs1_data for 00, ex_fwd_data for 01, mem_fwd_data for 10; code 11 SHALL select rs1_data. b_sel uses forward_b and rs2 on the same rules.
REQ-020 Load-use hazard lu = id_valid & ex_valid & ex_is_load & !ex_wr_reg_n & (ex_rd != 0) & ((id_rs1 == ex_rd) | (id_rs2 == ex_rd)), evaluated against the registered ex_* outputs.
REQ-021 stall = hold | (lu & !flush), combinational.
REQ-022 Update priority each edge: rst > hold > flush > lu > normal.
REQ-023 hold=1: all ex_* registers and stall_cnt SHALL keep their values.
REQ-024 flush=1 (no hold): ex_valid<=0, ex_wr_reg_n<=1, ex_is_load<=0; the other ex_* fields are don't-care but SHALL be written with the ID values.
REQ-025 lu=1 (no hold, no flush): insert a bubble as in REQ-024; stall_cnt<=stall_cnt+1, saturating at 16'hFFFF.
REQ-026 Normal: ex_valid<=id_valid, ex_pc<=id_pc, ex_a<=a_sel, ex_b<=b_sel, ex_rd<=id_rd, ex_is_load<=id_is_load & id_valid, ex_wr_reg_n<=id_wr_reg_n | !id_valid.
REQ-027 A bubble SHALL last exactly one cycle per load-use; in the next cycle ex_valid=0, so lu deasserts and the held ID instruction enters EX with the MEM-stage forward.
REQ-028 Latency: one cycle from ID inputs to ex_* outputs; no combinational path from ID inputs to ex_* outputs.
REQ-029 id_valid=0 SHALL never raise lu or increment stall_cnt.

Reset
REQ-030 rst=1 at an edge: ex_valid=0, ex_wr_reg_n=1, ex_is_load=0, ex_pc=0, ex_a=0, ex_b=0, ex_rd=0, stall_cnt=0; rst SHALL override hold and flush.
REQ-031 stall SHALL be 0 in the first cycle after reset unless hold=1.

Verification
REQ-032 Forward select: rs1_data=0x11, ex_fwd_data=0x22, mem_fwd_data=0x33, forward_a=01, forward_b=10, id_valid=1 -> next cycle ex_a=0x22, ex_b=0x33, ex_valid=1; forward_a=11 -> ex_a=0x11.
REQ-033 Load-use: load with rd=x5 in EX, ID has rs2=5 -> stall=1, next cycle ex_valid=0, ex_wr_reg_n=1, stall_cnt=1; following cycle stall=0 and the ID instruction latched.
REQ-034 x0 or no-write: load in EX with rd=0, or with ex_wr_reg_n=1, ID rs1=0 -> stall=0, no bubble, stall_cnt unchanged.
REQ-035 Priority: lu and flush together -> stall=0, bubble, stall_cnt unchanged; hold=1 with lu -> stall=1, ex_* and stall_cnt frozen.
REQ-036 Saturation and reset: preload stall_cnt=0xFFFF, then a load-use -> stays 0xFFFF; assert rst mid-hold -> all outputs at REQ-030 values next edge.

Source files
------------

// File: rtl/id_ex_operand_u.sv
// rtl/id_ex_operand_u.sv - ID/EX pipeline register with operand forwarding mux and load-use bubble insertion.
module id_ex_operand_u (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_wr_reg_n,
  input  logic        id_is_load,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [1:0]  forward_a,
  input  logic [1:0]  forward_b,
  input  logic [31:0] ex_fwd_data,
  input  logic [31:0] mem_fwd_data,
  input  logic        flush,
  input  logic        hold,
  output logic        stall,
  output logic        ex_valid,
  output logic        ex_wr_reg_n,
  output logic        ex_is_load,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [4:0]  ex_rd,
  output logic [15:0] stall_cnt
);

  logic        ex_valid_q, ex_valid_d;
  logic        ex_wr_reg_n_q, ex_wr_reg_n_d;
  logic        ex_is_load_q, ex_is_load_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [31:0] ex_a_q, ex_a_d;
  logic [31:0] ex_b_q, ex_b_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] a_sel, b_sel;
  logic        lu;

  // Code 11 is unused by the forwarding unit and falls back to the regfile value.
  always_comb begin
    case (forward_a)
      2'b01:   a_sel = ex_fwd_data;
      2'b10:   a_sel = mem_fwd_data;
      default: a_sel = rs1_data;
    endcase
    case (forward_b)
      2'b01:   b_sel = ex_fwd_data;
      2'b10:   b_sel = mem_fwd_data;
      default: b_sel = rs2_data;
    endcase
  end

  assign lu = id_valid & ex_valid_q & ex_is_load_q & ~ex_wr_reg_n_q &
              (ex_rd_q != 5'd0) & ((id_rs1 == ex_rd_q) | (id_rs2 == ex_rd_q));

  assign stall = hold | (lu & ~flush);

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_wr_reg_n_d = ex_wr_reg_n_q;
    ex_is_load_d  = ex_is_load_q;
    ex_pc_d       = ex_pc_q;
    ex_a_d        = ex_a_q;
    ex_b_d        = ex_b_q;
    ex_rd_d       = ex_rd_q;
    stall_cnt_d   = stall_cnt_q;
    if (!hold) begin
      // Data fields always track ID; a bubble only kills the control bits.
      ex_pc_d = id_pc;
      ex_a_d  = a_sel;
      ex_b_d  = b_sel;
      ex_rd_d = id_rd;
      if (flush || lu) begin
        ex_valid_d    = 1'b0;
        ex_wr_reg_n_d = 1'b1;
        ex_is_load_d  = 1'b0;
        if (!flush && stall_cnt_q != 16'hFFFF) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
      end else begin
        ex_valid_d    = id_valid;
        ex_wr_reg_n_d = id_wr_reg_n | ~id_valid;
        ex_is_load_d  = id_is_load & id_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_wr_reg_n_q <= 1'b1;
      ex_is_load_q  <= 1'b0;
      ex_pc_q       <= 32'd0;
      ex_a_q        <= 32'd0;
      ex_b_q        <= 32'd0;
      ex_rd_q       <= 5'd0;
      stall_cnt_q   <= 16'd0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_wr_reg_n_q <= ex_wr_reg_n_d;
      ex_is_load_q  <= ex_is_load_d;
      ex_pc_q       <= ex_pc_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      ex_rd_q       <= ex_rd_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_wr_reg_n = ex_wr_reg_n_q;
  assign ex_is_load  = ex_is_load_q;
  assign ex_pc       = ex_pc_q;
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign ex_rd       = ex_rd_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_u.sv
// tb/tb_id_ex_operand_u.sv - directed checks of forwarding, load-use bubbles, priority, saturation and reset.
module tb_id_ex_operand_u;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_wr_reg_n, id_is_load, flush, hold;
  logic [31:0] id_pc, rs1_data, rs2_data, ex_fwd_data, mem_fwd_data;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  forward_a, forward_b;
  logic        stall, ex_valid, ex_wr_reg_n, ex_is_load;
  logic [31:0] ex_pc, ex_a, ex_b;
  logic [4:0]  ex_rd;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_operand_u dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_wr_reg_n(id_wr_reg_n), .id_is_load(id_is_load),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .forward_a(forward_a), .forward_b(forward_b),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
    .flush(flush), .hold(hold), .stall(stall),
    .ex_valid(ex_valid), .ex_wr_reg_n(ex_wr_reg_n), .ex_is_load(ex_is_load),
    .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd,
                        input logic wn, input logic ld);
    id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_wr_reg_n = wn; id_is_load = ld;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_wrn"},   {31'd0, ex_wr_reg_n}, 32'd1);
    chk({tag, "_load"},  {31'd0, ex_is_load}, 32'd0);
    chk({tag, "_pc"},    ex_pc, 32'd0);
    chk({tag, "_a"},     ex_a, 32'd0);
    chk({tag, "_b"},     ex_b, 32'd0);
    chk({tag, "_rd"},    {27'd0, ex_rd}, 32'd0);
    chk({tag, "_cnt"},   {16'd0, stall_cnt}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b1; flush = 1'b1;
    rs1_data = 32'h0; rs2_data = 32'h0; ex_fwd_data = 32'h0; mem_fwd_data = 32'h0;
    forward_a = 2'b00; forward_b = 2'b00;
    set_id(1'b1, 32'hDEAD, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1);
    step();
    chk_reset("rst");
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // Forward selection
    rs1_data = 32'h11; rs2_data = 32'h44; ex_fwd_data = 32'h22; mem_fwd_data = 32'h33;
    forward_a = 2'b01; forward_b = 2'b10;
    set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    step();
    chk("fwd_a_ex", ex_a, 32'h22);
    chk("fwd_b_mem", ex_b, 32'h33);
    chk("fwd_valid", {31'd0, ex_valid}, 32'd1);
    chk("fwd_pc", ex_pc, 32'h100);
    chk("fwd_rd", {27'd0, ex_rd}, 32'd3);
    chk("fwd_wrn", {31'd0, ex_wr_reg_n}, 32'd0);
    forward_a = 2'b11; forward_b = 2'b00;
    step();
    chk("fwd_a_11", ex_a, 32'h11);
    chk("fwd_b_rf", ex_b, 32'h44);

    // Load-use on rs2
    set_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
    step();
    chk("lu_ld_in_ex", {31'd0, ex_is_load}, 32'd1);
    set_id(1'b1, 32'h204, 5'd7, 5'd5, 5'd6, 1'b0, 1'b0);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    step();
    chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bub_wrn", {31'd0, ex_wr_reg_n}, 32'd1);
    chk("lu_bub_load", {31'd0, ex_is_load}, 32'd0);
    chk("lu_cnt1", {16'd0, stall_cnt}, 32'd1);
    chk("lu_stall_clr", {31'd0, stall}, 32'd0);
    forward_b = 2'b10; mem_fwd_data = 32'h55;
    #1;
    step();
    chk("lu_after_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_after_pc", ex_pc, 32'h204);
    chk("lu_after_b", ex_b, 32'h55);
    chk("lu_after_rd", {27'd0, ex_rd}, 32'd6);
    chk("lu_after_cnt", {16'd0, stall_cnt}, 32'd1);
    forward_b = 2'b00;

    // Load to x0, then load with no write: neither stalls
    set_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    step();
    set_id(1'b1, 32'h304, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0);
    chk("x0_stall", {31'd0, stall}, 32'd0);
    set_id(1'b1, 32'h308, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
    step();
    chk("nw_load", {31'd0, ex_is_load}, 32'd1);
    chk("nw_wrn", {31'd0, ex_wr_reg_n}, 32'd1);
    set_id(1'b1, 32'h30C, 5'd4, 5'd4, 5'd8, 1'b0, 1'b0);
    chk("nw_stall", {31'd0, stall}, 32'd0);
    step();
    chk("nw_valid", {31'd0, ex_valid}, 32'd1);
    chk("nw_cnt", {16'd0, stall_cnt}, 32'd1);

    // Invalid ID never raises a load-use
    set_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
    step();
    set_id(1'b0, 32'h404, 5'd5, 5'd5, 5'd9, 1'b0, 1'b1);
    chk("inv_stall", {31'd0, stall}, 32'd0);
    step();
    chk("inv_valid", {31'd0, ex_valid}, 32'd0);
    chk("inv_wrn", {31'd0, ex_wr_reg_n}, 32'd1);
    chk("inv_load", {31'd0, ex_is_load}, 32'd0);
    chk("inv_cnt", {16'd0, stall_cnt}, 32'd1);

    // Flush beats load-use
    set_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
    step();
    set_id(1'b1, 32'h504, 5'd5, 5'd2, 5'd9, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_stall", {31'd0, stall}, 32'd0);
    step();
    flush = 1'b0;
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_pc", ex_pc, 32'h504);
    chk("fl_cnt", {16'd0, stall_cnt}, 32'd1);

    // Hold beats load-use and freezes everything
    set_id(1'b1, 32'h600, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
    step();
    set_id(1'b1, 32'h604, 5'd5, 5'd2, 5'd9, 1'b0, 1'b0);
    hold = 1'b1;
    #1;
    chk("hd_stall", {31'd0, stall}, 32'd1);
    step();
    step();
    chk("hd_valid", {31'd0, ex_valid}, 32'd1);
    chk("hd_load", {31'd0, ex_is_load}, 32'd1);
    chk("hd_pc", ex_pc, 32'h600);
    chk("hd_rd", {27'd0, ex_rd}, 32'd5);
    chk("hd_cnt", {16'd0, stall_cnt}, 32'd1);
    hold = 1'b0;
    #1;
    chk("hd_rel_stall", {31'd0, stall}, 32'd1);
    step();
    chk("hd_rel_valid", {31'd0, ex_valid}, 32'd0);
    chk("hd_rel_cnt", {16'd0, stall_cnt}, 32'd2);

    // Saturation: counter is preset just below the ceiling
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    set_id(1'b1, 32'h700, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
    step();
    set_id(1'b1, 32'h704, 5'd5, 5'd2, 5'd9, 1'b0, 1'b0);
    step();
    chk("sat_ffff", {16'd0, stall_cnt}, 32'hFFFF);
    step();
    set_id(1'b1, 32'h708, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
    step();
    set_id(1'b1, 32'h70C, 5'd1, 5'd5, 5'd9, 1'b0, 1'b0);
    chk("sat_stall", {31'd0, stall}, 32'd1);
    step();
    chk("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
    chk("sat_bub", {31'd0, ex_valid}, 32'd0);

    // Reset asserted in the middle of a hold
    step();
    hold = 1'b1;
    step();
    chk("rh_frozen_valid", {31'd0, ex_valid}, 32'd1);
    rst = 1'b1; flush = 1'b1;
    step();
    chk_reset("rh");
    chk("rh_stall_hold", {31'd0, stall}, 32'd1);
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
    #1;
    chk("rh_stall_clr", {31'd0, stall}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
